// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings and default widths for the ALU accumulator stage
package alu_pkg;

    localparam int DEF_WIDTH = 9;
    localparam int DEF_CNT_W = 6;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_ADC  = 2'b10,
        OP_MULR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_accumulator_if.sv
// rtl/alu_accumulator_if.sv - start/busy/done handshake between control unit and accumulator
interface alu_accumulator_if #(
    parameter int WIDTH = 9,
    parameter int CNT_W = 6
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] acc;
    logic             carry;

    // control unit side
    modport master (
        output start, op, operand, count,
        input  busy, done, acc, carry
    );

    // accumulator side
    modport slave (
        input  start, op, operand, count,
        output busy, done, acc, carry
    );
endinterface

// File: rtl/alu_accumulator.sv
// rtl/alu_accumulator.sv - accumulator, carry flag and sequencing around the external ALU
module alu_accumulator
    import alu_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_accumulator_if.slave bus,
    output logic [WIDTH-1:0] alu_a1,
    output logic [WIDTH-1:0] alu_a2,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_o
);

    state_t           state;
    op_t              op_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] operand_reg;
    logic [CNT_W-1:0] remaining;
    logic             carry_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             wrap;

    assign alu_a1    = acc_reg;
    assign alu_a2    = operand_reg;
    assign bus.acc   = acc_reg;
    assign bus.carry = carry_reg;
    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;

    // Carry-in only feeds the ALU while an ADC step is actually executing.
    always_comb begin
        alu_cin = 1'b0;
        if (state == ST_RUN && op_reg == OP_ADC) begin
            alu_cin = carry_reg;
        end
    end

    // Unsigned modulo overflow: result fell below a1, or equalled it with a carry-in
    // (a2 + cin == 2^WIDTH exactly).
    always_comb begin
        wrap = (alu_o < alu_a1) || (alu_cin && (alu_o == alu_a1));
    end

    // Sequencer FSM with registered busy/done and the accumulator datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            op_reg      <= OP_LOAD;
            acc_reg     <= '0;
            operand_reg <= '0;
            remaining   <= '0;
            carry_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_reg      <= op_t'(bus.op);
                        operand_reg <= bus.operand;
                        busy_reg    <= 1'b1;
                        case (op_t'(bus.op))
                            OP_LOAD: begin
                                acc_reg   <= bus.operand;
                                carry_reg <= 1'b0;
                                remaining <= '0;
                                state     <= ST_DONE;
                                done_reg  <= 1'b1;
                            end
                            OP_ADD, OP_ADC: begin
                                remaining <= CNT_W'(1);
                                state     <= ST_RUN;
                            end
                            default: begin
                                acc_reg   <= '0;
                                carry_reg <= 1'b0;
                                remaining <= bus.count;
                                if (bus.count == '0) begin
                                    state    <= ST_DONE;
                                    done_reg <= 1'b1;
                                end else begin
                                    state <= ST_RUN;
                                end
                            end
                        endcase
                    end
                end
                ST_RUN: begin
                    acc_reg   <= alu_o;
                    remaining <= remaining - CNT_W'(1);
                    if (op_reg == OP_MULR) begin
                        carry_reg <= carry_reg | wrap;
                    end else begin
                        carry_reg <= wrap;
                    end
                    if (remaining == CNT_W'(1)) begin
                        state    <= ST_DONE;
                        done_reg <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    busy_reg <= 1'b0;
                    done_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_accumulator.sv
// tb/tb_alu_accumulator.sv - directed table-driven bench for alu_accumulator
module tb_alu_accumulator;
    import alu_pkg::*;

    localparam int WIDTH = 9;
    localparam int CNT_W = 6;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] alu_a1;
    logic [WIDTH-1:0] alu_a2;
    logic             alu_cin;
    logic [WIDTH-1:0] alu_o;

    int checks = 0;
    int errors = 0;

    alu_accumulator_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    alu_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .alu_a1  (alu_a1),
        .alu_a2  (alu_a2),
        .alu_cin (alu_cin),
        .alu_o   (alu_o)
    );

    // Reference combinational ALU sitting beside the block.
    assign alu_o = alu_a1 + alu_a2 + {{(WIDTH-1){1'b0}}, alu_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       op;
        logic [WIDTH-1:0] operand;
        logic [CNT_W-1:0] count;
        logic [WIDTH-1:0] exp_acc;
        logic             exp_carry;
        int               exp_busy;
        logic             exp_cin;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request and watch the busy window; returns what was observed.
    task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] operand,
                          input logic [CNT_W-1:0] count, output int busy_cyc,
                          output int done_at, output int done_cnt, output logic cin_seen);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.operand = operand;
        bus.count   = count;
        @(negedge clk);
        bus.start = 1'b0;
        busy_cyc = 0;
        done_at  = 0;
        done_cnt = 0;
        cin_seen = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (k > 1) @(negedge clk);
            if (!bus.busy) break;
            busy_cyc++;
            if (bus.done) begin
                done_cnt++;
                done_at = k;
            end
            if (alu_cin) cin_seen = 1'b1;
        end
    endtask

    int   bc, da, dc;
    logic cs;

    initial begin
        vecs[0]  = '{OP_LOAD, 9'h0FF, 6'd0, 9'h0FF, 1'b0, 1,  1'b0};
        vecs[1]  = '{OP_ADD,  9'h001, 6'd0, 9'h100, 1'b0, 2,  1'b0};
        vecs[2]  = '{OP_LOAD, 9'h1FF, 6'd0, 9'h1FF, 1'b0, 1,  1'b0};
        vecs[3]  = '{OP_ADD,  9'h001, 6'd0, 9'h000, 1'b1, 2,  1'b0};
        vecs[4]  = '{OP_ADC,  9'h005, 6'd0, 9'h006, 1'b0, 2,  1'b1};
        vecs[5]  = '{OP_MULR, 9'h007, 6'd9, 9'h03F, 1'b0, 10, 1'b0};
        vecs[6]  = '{OP_MULR, 9'h100, 6'd3, 9'h100, 1'b1, 4,  1'b0};
        vecs[7]  = '{OP_MULR, 9'h055, 6'd0, 9'h000, 1'b0, 1,  1'b0};
        vecs[8]  = '{OP_LOAD, 9'h1FF, 6'd0, 9'h1FF, 1'b0, 1,  1'b0};
        vecs[9]  = '{OP_ADD,  9'h001, 6'd0, 9'h000, 1'b1, 2,  1'b0};
        vecs[10] = '{OP_ADC,  9'h1FF, 6'd0, 9'h000, 1'b1, 2,  1'b1};

        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.operand = '0;
        bus.count   = '0;
        rst_n       = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_acc",   int'(bus.acc),   0);
        check("reset_carry", int'(bus.carry), 0);
        check("reset_busy",  int'(bus.busy),  0);
        check("reset_done",  int'(bus.done),  0);
        check("reset_cin",   int'(alu_cin),   0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].operand, vecs[i].count, bc, da, dc, cs);
            check($sformatf("v%0d_acc", i),     int'(bus.acc),   int'(vecs[i].exp_acc));
            check($sformatf("v%0d_carry", i),   int'(bus.carry), int'(vecs[i].exp_carry));
            check($sformatf("v%0d_busy", i),    bc,              vecs[i].exp_busy);
            check($sformatf("v%0d_done_at", i), da,              vecs[i].exp_busy);
            check($sformatf("v%0d_done_cnt", i), dc,             1);
            check($sformatf("v%0d_cin", i),     int'(cs),        int'(vecs[i].exp_cin));
        end

        // Start pulses during RUN and during DONE must be dropped.
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULR; bus.operand = 9'h007; bus.count = 6'd9;
        @(negedge clk);
        bus.start = 1'b0;
        bc = 0; dc = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (!bus.busy) break;
            bc++;
            if (bus.done) dc++;
            bus.start = (k == 3) || bus.done;
            bus.op = OP_ADD;
            bus.operand = 9'h055;
        end
        bus.start = 1'b0;
        check("ign_busy",  bc,                10);
        check("ign_done",  dc,                1);
        check("ign_acc",   int'(bus.acc),     9'h03F);
        check("ign_carry", int'(bus.carry),   0);
        check("ign_a2",    int'(alu_a2),      7);
        @(negedge clk);
        check("ign_noqueue", int'(bus.busy),  0);

        // Reset in the middle of a MULR run.
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULR; bus.operand = 9'h007; bus.count = 6'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy_pre", int'(bus.busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_acc",   int'(bus.acc),   0);
        check("rst_carry", int'(bus.carry), 0);
        check("rst_busy",  int'(bus.busy),  0);
        check("rst_done",  int'(bus.done),  0);
        check("rst_cin",   int'(alu_cin),   0);
        check("rst_a2",    int'(alu_a2),    0);
        rst_n = 1'b1;
        dc = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) dc++;
        end
        check("rst_no_done", dc, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_accumulator.md
# alu_accumulator

Sequencing and accumulator stage wrapped around the processor's combinational 9-bit ALU. It holds the accumulator and carry flag, drives the ALU operand inputs, and captures the ALU result back into the accumulator. It supports single-step load/add/add-with-carry and a multi-cycle multiply-by-repeated-addition. A start/busy/done handshake connects it to the control unit.

## Interface
- WIDTH, 9 — datapath width; matches the ALU operand/result width.
- CNT_W, 6 — width of the repeat count for MULR (max 63 iterations).

- clk  in  1  — single clock; all state updates on rising edge.
- rst_n  in  1  — reset, synchronous, active-low.
- start  in  1  — request; sampled only when busy=0.
- op  in  2  — 00 LOAD, 01 ADD, 10 ADC, 11 MULR.
- operand  in  WIDTH  — data operand, latched on accept.
- count  in  CNT_W  — MULR iteration count, latched on accept; ignored otherwise.
- busy  out  1  — high when state ≠ IDLE.
- done  out  1  — one-cycle pulse, high in state DONE.
- acc  out  WIDTH  — accumulator register.
- carry  out  1  — carry/wrap flag register.
- alu_a1  out  WIDTH  — to ALU a1; always = acc.
- alu_a2  out  WIDTH  — to ALU a2; always = latched operand.
- alu_cin  out  1  — to ALU cin.
- alu_o  in  WIDTH  — ALU result; combinational, same cycle.

## Operation
- States: IDLE, RUN, DONE. Reset values are state=IDLE, acc=0, carry=0, operand_reg=0, remaining=0, op_reg=LOAD, busy=0, done=0.
- Accept happens on an edge with state=IDLE and start=1. That edge latches op_reg, operand_reg and remaining.
  - LOAD: acc←operand, carry←0, go to DONE. The ALU is not used.
  - ADD / ADC: remaining←1, go to RUN.
  - MULR: acc←0, carry←0, remaining←count. If count=0, go to DONE; otherwise go to RUN.
- alu_cin is carry for ADC in RUN and 0 in every other case.
- RUN, each edge:
  - acc←alu_o.
  - wrap = (alu_o < alu_a1) or (alu_cin and alu_o == alu_a1). This is unsigned modulo-2^WIDTH overflow.
  - ADD/ADC: carry←wrap. MULR: carry←carry or wrap (sticky).
  - remaining←remaining−1. If remaining was 1, go to DONE.
- DONE: done=1 for exactly one cycle, then go unconditionally to IDLE.
- start while busy=1, including in DONE, is ignored and not queued.
- Arithmetic is modulo 2^WIDTH. There is no saturation. The ALU's internal carry-out is unused; wrap detection is local.
- rst_n low on any edge, including mid-RUN, forces all reset values on that edge. Any in-flight operation is abandoned with no done pulse.

## Timing
- Let E0 be the accept edge.
- LOAD: acc valid after E0; done high in the cycle after E0.
- ADD/ADC: RUN for one cycle; acc/carry update at E1; done in the cycle after E1.
- MULR with count=n≥1: RUN for n cycles; final acc at En; done in the cycle after En.
- MULR with count=0: acc=0 and done in the cycle after E0.
- Minimum spacing between accepts is 2 cycles (LOAD, MULR n=0), 3 cycles (ADD/ADC) and n+2 cycles (MULR).
- acc and carry are stable from the done cycle until the next accept.

## Structure
- The shared package (alu_pkg) holds the op encodings (OP_LOAD, OP_ADD, OP_ADC, OP_MULR), the state encodings, and the default WIDTH/CNT_W.
- There is no sub-module: the ALU is instantiated beside this block at the top level. The FSM, counter and registers are one module, roughly 150 lines.

## Test plan
- Reset: hold rst_n low for 2 edges → acc=0x000, carry=0, busy=0, done=0, alu_cin=0.
- LOAD 0x0FF, then ADD 0x001 → acc=0x100, carry=0. done pulses one cycle after E1, and busy is high for exactly 2 cycles.
- LOAD 0x1FF, ADD 0x001 → acc=0x000, carry=1. Then ADC 0x005 → alu_cin=1 in RUN, acc=0x006, carry=0.
- MULR with operand 7, count 9 → busy high for 10 cycles, acc=0x03F, carry=0. MULR with count 0 → acc=0x000, done in the cycle after accept.
- MULR with operand 0x100, count 3 → acc=0x100 (768 mod 512), carry=1 (sticky).
- Pulse start with ADD 0x055 during a MULR RUN → no effect, and the MULR result is unchanged. Drive rst_n low mid-MULR → all outputs return to reset values on that edge, with no done pulse.
